// File: rtl/btn_debounce.sv
// Push-button front end: two-flop sync, counter debounce, registered press/release strobes and a
// modulo-16 press count. Define AUTO_REPEAT_EN to add hold-to-repeat press strobes.
module btn_debounce #(
    parameter int unsigned ACTIVE_LOW      = 1,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned HOLD_CYCLES     = 25000000,
    parameter int unsigned REPEAT_CYCLES   = 5000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       button,
    output logic       level,
    output logic       press,
    output logic       rel,        // release strobe
    output logic [3:0] press_cnt
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic RAW_RELEASED = (ACTIVE_LOW != 0);

    if (DEBOUNCE_CYCLES < 2 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_cfg
        $error("btn_debounce: invalid timing parameters");
    end

    logic             sync_r;
    logic             sync_rr;
    logic [CNT_W-1:0] cnt;
    logic             pressed_c;
    logic             differ_c;
    logic             accept_c;
    logic             press_c;
    logic             release_c;

    // Sync flops reset to the idle raw level so reset exit never looks like an edge
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r  <= RAW_RELEASED;
            sync_rr <= RAW_RELEASED;
        end else begin
            sync_r  <= button;
            sync_rr <= sync_r;
        end
    end

    assign pressed_c = (ACTIVE_LOW != 0) ? ~sync_rr : sync_rr;
    assign differ_c  = (pressed_c != level);
    assign accept_c  = differ_c && (cnt == CNT_MAX);
    assign release_c = accept_c && !pressed_c;

    // Any sample matching the accepted level restarts the count
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (!differ_c || accept_c) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam int unsigned MAX_T = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned TMR_W = $clog2(MAX_T + 1);
    localparam logic [TMR_W-1:0] HOLD_LAST   = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] REPEAT_LAST = TMR_W'(REPEAT_CYCLES - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HOLD   = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [TMR_W-1:0] tmr;
    logic [TMR_W-1:0] tmr_next;
    logic             repeat_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            tmr   <= '0;
        end else begin
            state <= state_next;
            tmr   <= tmr_next;
        end
    end

    // An accepted level change always takes priority, so a repeat never collides with release
    always_comb begin
        state_next = state;
        tmr_next   = tmr;
        repeat_c   = 1'b0;
        if (accept_c) begin
            state_next = pressed_c ? ST_HOLD : ST_IDLE;
            tmr_next   = '0;
        end else if (!level) begin
            state_next = ST_IDLE;
            tmr_next   = '0;
        end else begin
            case (state)
                ST_HOLD: begin
                    if (tmr == HOLD_LAST) begin
                        repeat_c   = 1'b1;
                        state_next = ST_REPEAT;
                        tmr_next   = '0;
                    end else begin
                        tmr_next = tmr + TMR_W'(1);
                    end
                end
                ST_REPEAT: begin
                    if (tmr == REPEAT_LAST) begin
                        repeat_c = 1'b1;
                        tmr_next = '0;
                    end else begin
                        tmr_next = tmr + TMR_W'(1);
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    tmr_next   = '0;
                end
            endcase
        end
    end

    assign press_c = (accept_c && pressed_c) || repeat_c;
`else
    assign press_c = accept_c && pressed_c;
`endif

    // Strobes are registered alongside the level update, so they appear with the new level
    always_ff @(posedge clk) begin
        if (rst) begin
            level     <= 1'b0;
            press     <= 1'b0;
            rel       <= 1'b0;
            press_cnt <= 4'd0;
        end else begin
            if (accept_c) begin
                level <= pressed_c;
            end
            press     <= press_c;
            rel       <= release_c;
            press_cnt <= press_cnt + 4'(press_c);
        end
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Scoreboard bench for btn_debounce: stimulus queues expected strobes, a negedge monitor checks them.
module tb_btn_debounce;

    localparam int unsigned DEB  = 4;
    localparam int unsigned HOLD = 10;
    localparam int unsigned REP  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       button;
    logic       level;
    logic       press;
    logic       rel;
    logic [3:0] press_cnt;

    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic        is_press;
        int unsigned at;
        logic [3:0]  cnt;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    btn_debounce #(
        .ACTIVE_LOW      (1),
        .DEBOUNCE_CYCLES (DEB),
        .HOLD_CYCLES     (HOLD),
        .REPEAT_CYCLES   (REP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .button    (button),
        .level     (level),
        .press     (press),
        .rel       (rel),
        .press_cnt (press_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_strobe(input logic p, input int unsigned at, input logic [3:0] c);
        exp_t e;
        e.is_press = p;
        e.at       = at;
        e.cnt      = c;
        sb.push_back(e);
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every strobe must match the head of the scoreboard in kind, cycle and count
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].at < cyc) begin
            checks++;
            errors++;
            $display("FAIL missed_strobe: expected press=%0d at cycle %0d did not occur", sb[0].is_press, sb[0].at);
            void'(sb.pop_front());
        end
        if (press === 1'b1 && rel === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL both_strobes: press and release high at cycle %0d", cyc);
        end else if (press === 1'b1 || rel === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: press=%0d release=%0d at cycle %0d, none expected", press, rel, cyc);
            end else begin
                mon_e = sb.pop_front();
                checks++;
                if (mon_e.is_press !== press || mon_e.at != cyc) begin
                    errors++;
                    $display("FAIL strobe_timing: got press=%0d at cycle %0d expected press=%0d at cycle %0d",
                             press, cyc, mon_e.is_press, mon_e.at);
                end
                checks++;
                if (press_cnt !== mon_e.cnt) begin
                    errors++;
                    $display("FAIL strobe_cnt: got %0d expected %0d at cycle %0d", press_cnt, mon_e.cnt, cyc);
                end
                checks++;
                if (level !== mon_e.is_press) begin
                    errors++;
                    $display("FAIL strobe_level: got %0d expected %0d at cycle %0d", level, mon_e.is_press, cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned t0;
        rst    = 1'b1;
        button = 1'b1;

        // Reset held with button released
        step(3);
        check("rst_level", int'(level), 0);
        check("rst_press", int'(press), 0);
        check("rst_release", int'(rel), 0);
        check("rst_cnt", int'(press_cnt), 0);
        rst = 1'b0;
        step(10);
        check("post_rst_level", int'(level), 0);
        check("post_rst_cnt", int'(press_cnt), 0);

        // Bounce: only three low samples, one short of acceptance
        button = 1'b0;
        step(3);
        button = 1'b1;
        step(12);
        check("bounce_level", int'(level), 0);
        check("bounce_cnt", int'(press_cnt), 0);

        // Clean press
        t0 = cyc;
        button = 1'b0;
        expect_strobe(1'b1, t0 + 6, 4'd1);
        step(10);
        check("press_level", int'(level), 1);
        check("press_cnt", int'(press_cnt), 1);

        // Clean release
        t0 = cyc;
        button = 1'b1;
        expect_strobe(1'b0, t0 + 6, 4'd1);
        step(10);
        check("release_level", int'(level), 0);
        check("release_cnt", int'(press_cnt), 1);

        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("rst2_cnt", int'(press_cnt), 0);
        step(3);

        // Seventeen press/release pairs: count wraps through zero
        for (int k = 0; k < 17; k++) begin
            t0 = cyc;
            button = 1'b0;
            expect_strobe(1'b1, t0 + 6, 4'(k + 1));
            step(10);
            button = 1'b1;
            expect_strobe(1'b0, t0 + 16, 4'(k + 1));
            step(10);
        end
        check("wrap_cnt", int'(press_cnt), 1);
        check("wrap_level", int'(level), 0);

        // Reset during a pending press restarts the debounce from scratch
        t0 = cyc;
        button = 1'b0;
        step(3);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("midrst_level", int'(level), 0);
        check("midrst_cnt", int'(press_cnt), 0);
        expect_strobe(1'b1, t0 + 10, 4'd1);
        step(12);
        check("midrst_press_level", int'(level), 1);
        check("midrst_press_cnt", int'(press_cnt), 1);
        t0 = cyc;
        button = 1'b1;
        expect_strobe(1'b0, t0 + 6, 4'd1);
        step(10);

        // Long hold: auto-repeat strobes when enabled, a single press otherwise
        t0 = cyc;
        button = 1'b0;
        expect_strobe(1'b1, t0 + 6, 4'd2);
`ifdef AUTO_REPEAT_EN
        expect_strobe(1'b1, t0 + 16, 4'd3);
        expect_strobe(1'b1, t0 + 19, 4'd4);
        expect_strobe(1'b1, t0 + 22, 4'd5);
        expect_strobe(1'b1, t0 + 25, 4'd6);
        expect_strobe(1'b1, t0 + 28, 4'd7);
`endif
        step(24);
        button = 1'b1;
`ifdef AUTO_REPEAT_EN
        expect_strobe(1'b0, t0 + 30, 4'd7);
        step(12);
        check("hold_cnt", int'(press_cnt), 7);
`else
        expect_strobe(1'b0, t0 + 30, 4'd2);
        step(12);
        check("hold_cnt", int'(press_cnt), 2);
`endif
        check("hold_level", int'(level), 0);

        step(5);
        check("scoreboard_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
